// File: rtl/EthernetBufferPkg.sv
// EthernetBufferPkg: MAC receive bus, stored RAM word and FSM state types for the RX frame buffer.
package EthernetBufferPkg;
  typedef struct packed {
    logic        start;
    logic        data_valid;
    logic [2:0]  bytes_valid;
    logic [31:0] data;
    logic        commit;
    logic        drop;
  } EthernetRxBus;
  typedef struct packed {
    logic [2:0]  bytes_valid;
    logic [31:0] data;
  } EthRxWord;
  typedef enum logic [1:0] {IDLE, FRAME, DISCARD} wr_state_e;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_STREAM} rd_state_e;
endpackage

// File: rtl/eth_rx_buffer_ram.sv
// eth_rx_buffer_ram: simple dual-port word store with a registered read port and no reset.
module eth_rx_buffer_ram #(
  parameter int DEPTH = 1024,
  parameter int W = 35
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/eth_rx_frame_buffer.sv
// eth_rx_frame_buffer: speculative RX frame store, publishing frames on commit and replaying them as a word stream.
module eth_rx_frame_buffer
  import EthernetBufferPkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int MAX_FRAMES = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  EthernetRxBus rx_bus,
  output logic         out_frame_valid,
  output logic [15:0]  out_frame_len,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_data,
  output logic [2:0]   out_bytes_valid,
  output logic         out_last,
  output logic [31:0]  perf_frames,
  output logic [31:0]  perf_crc_drops,
  output logic [31:0]  perf_overflows
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int FW = $clog2(MAX_FRAMES) + 1;
  wr_state_e wr_state_q, wr_state_d;
  rd_state_e rd_state_q, rd_state_d;
  logic [PW-1:0] wr_commit_q, wr_commit_d, wr_tmp_q, wr_tmp_d, rd_ptr_q, rd_ptr_d;
  logic [FW-1:0] dw_q, dw_d, dr_q, dr_d;
  logic [15:0] len_q, len_d, rem_q, rem_d, flen_q, flen_d, rem_nx;
  logic [31:0] frames_q, frames_d, crc_q, crc_d, ovf_q, ovf_d;
  logic [15:0] desc_q [MAX_FRAMES];
  logic [16:0] len_sum;
  EthRxWord out_q, out_d, ram_wdata, ram_rdata;
  logic out_valid_q, out_valid_d, out_last_q, out_last_d, fv_q, fv_d;
  logic ram_full, desc_full, push, hs, ram_we;
  logic [AW-1:0] ram_raddr;
  assign ram_full  = (wr_tmp_q - rd_ptr_q) == PW'(DEPTH);
  assign desc_full = (dw_q - dr_q) == FW'(MAX_FRAMES);
  assign len_sum   = {1'b0, len_q} + 17'(rx_bus.bytes_valid);
  assign ram_wdata = '{bytes_valid: rx_bus.bytes_valid, data: rx_bus.data};
  always_comb begin
    wr_state_d  = wr_state_q;
    wr_commit_d = wr_commit_q;
    wr_tmp_d    = wr_tmp_q;
    len_d       = len_q;
    frames_d    = frames_q;
    crc_d       = crc_q;
    ovf_d       = ovf_q;
    push        = 1'b0;
    ram_we      = 1'b0;
    if (rx_bus.start) begin
      wr_state_d = FRAME;
      wr_tmp_d   = wr_commit_q;
      len_d      = '0;
    end else if (wr_state_q == FRAME) begin
      if (rx_bus.drop) begin
        wr_state_d = IDLE;
        wr_tmp_d   = wr_commit_q;
        crc_d      = crc_q + 32'd1;
      end else if (rx_bus.commit) begin
        wr_state_d = IDLE;
        // an empty frame has no words to replay, so it is not published
        if (len_q != '0 && !desc_full) begin
          push        = 1'b1;
          wr_commit_d = wr_tmp_q;
          frames_d    = frames_q + 32'd1;
        end else begin
          wr_tmp_d = wr_commit_q;
          ovf_d    = (len_q != '0) ? ovf_q + 32'd1 : ovf_q;
        end
      end else if (rx_bus.data_valid) begin
        if (!ram_full) begin
          ram_we   = 1'b1;
          wr_tmp_d = wr_tmp_q + PW'(1);
          len_d    = len_sum[16] ? 16'hFFFF : len_sum[15:0];
        end else begin
          wr_state_d = DISCARD;
          wr_tmp_d   = wr_commit_q;
          ovf_d      = ovf_q + 32'd1;
        end
      end
    end else if (wr_state_q == DISCARD && (rx_bus.commit || rx_bus.drop)) begin
      wr_state_d = IDLE;
    end
  end
  assign hs     = out_valid_q && out_ready;
  assign dw_d   = dw_q + FW'(push);
  assign dr_d   = dr_q + FW'(hs && out_last_q);
  assign fv_d   = dw_q != dr_d;
  assign flen_d = fv_d ? desc_q[dr_d[FW-2:0]] : '0;
  assign rem_nx = rem_q - 16'd4;
  // the RAM output register doubles as the prefetch stage: it always holds the word after out_q
  always_comb begin
    rd_state_d  = rd_state_q;
    rd_ptr_d    = rd_ptr_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    rem_d       = rem_q;
    ram_raddr   = rd_ptr_q[AW-1:0];
    case (rd_state_q)
      R_FETCH: begin
        out_d       = ram_rdata;
        out_valid_d = 1'b1;
        rem_d       = flen_q;
        out_last_d  = flen_q <= 16'd4;
        ram_raddr   = rd_ptr_q[AW-1:0] + AW'(1);
        rd_state_d  = R_STREAM;
      end
      R_STREAM: begin
        ram_raddr = rd_ptr_q[AW-1:0] + AW'(1) + AW'(hs);
        if (hs) begin
          rd_ptr_d    = rd_ptr_q + PW'(1);
          out_d       = out_last_q ? '0 : ram_rdata;
          out_valid_d = !out_last_q;
          out_last_d  = !out_last_q && rem_nx <= 16'd4;
          rem_d       = out_last_q ? '0 : rem_nx;
          rd_state_d  = out_last_q ? R_IDLE : R_STREAM;
        end
      end
      default: rd_state_d = fv_q ? R_FETCH : R_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_state_q  <= IDLE;
      rd_state_q  <= R_IDLE;
      wr_commit_q <= '0;
      wr_tmp_q    <= '0;
      rd_ptr_q    <= '0;
      dw_q        <= '0;
      dr_q        <= '0;
      len_q       <= '0;
      rem_q       <= '0;
      flen_q      <= '0;
      fv_q        <= 1'b0;
      frames_q    <= '0;
      crc_q       <= '0;
      ovf_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      wr_state_q  <= wr_state_d;
      rd_state_q  <= rd_state_d;
      wr_commit_q <= wr_commit_d;
      wr_tmp_q    <= wr_tmp_d;
      rd_ptr_q    <= rd_ptr_d;
      dw_q        <= dw_d;
      dr_q        <= dr_d;
      len_q       <= len_d;
      rem_q       <= rem_d;
      flen_q      <= flen_d;
      fv_q        <= fv_d;
      frames_q    <= frames_d;
      crc_q       <= crc_d;
      ovf_q       <= ovf_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) desc_q[dw_q[FW-2:0]] <= len_q;
  end
  eth_rx_buffer_ram #(.DEPTH(DEPTH), .W(35)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_tmp_q[AW-1:0]),
    .wdata (ram_wdata),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );
  assign out_frame_valid = fv_q;
  assign out_frame_len   = flen_q;
  assign out_valid       = out_valid_q;
  assign out_data        = out_q.data;
  assign out_bytes_valid = out_q.bytes_valid;
  assign out_last        = out_last_q;
  assign perf_frames     = frames_q;
  assign perf_crc_drops  = crc_q;
  assign perf_overflows  = ovf_q;
endmodule

// File: tb/tb_eth_rx_frame_buffer.sv
// tb_eth_rx_frame_buffer: table of directed frames plus hand sequences for back-pressure and mid-frame reset.
module tb_eth_rx_frame_buffer;
  import EthernetBufferPkg::*;
  logic clk = 1'b0;
  logic rst_n;
  EthernetRxBus rx_bus;
  logic out_frame_valid, out_valid, out_ready, out_last;
  logic [15:0] out_frame_len;
  logic [31:0] out_data, perf_frames, perf_crc_drops, perf_overflows;
  logic [2:0] out_bytes_valid;
  always #5 clk = ~clk;
  eth_rx_frame_buffer #(.DEPTH(32), .MAX_FRAMES(4)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .rx_bus          (rx_bus),
    .out_frame_valid (out_frame_valid),
    .out_frame_len   (out_frame_len),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
    .out_bytes_valid (out_bytes_valid),
    .out_last        (out_last),
    .perf_frames     (perf_frames),
    .perf_crc_drops  (perf_crc_drops),
    .perf_overflows  (perf_overflows)
  );
  typedef struct {
    logic [31:0] d;
    logic [2:0]  bv;
    logic        last;
    logic [15:0] len;
    int          cyc;
  } beat_t;
  typedef struct {
    int nbytes;
    bit drop;
    int frames;
    int drops;
    int ovfs;
  } vec_t;
  beat_t rx_q[$], exp_q[$];
  vec_t vt[6];
  int n_cmp = 0, n_bad = 0, cyc = 0;
  bit toggle = 1'b0;
  logic hold_p = 1'b0;
  logic [35:0] held;
  logic [5:0] exp_ptr;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [31:0] word(input int id, input int w);
    return {8'(id), 8'(w), 8'h5A, 8'(id + w)};
  endfunction
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 out_ready = toggle ? !out_ready : 1'b1;
    end
  end
  always @(negedge clk) begin
    cyc++;
    if (rst_n && hold_p) begin
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_word", 64'({out_last, out_bytes_valid, out_data}), 64'(held));
    end
    if (rst_n && out_valid && out_ready)
      rx_q.push_back('{out_data, out_bytes_valid, out_last, out_frame_len, cyc});
    hold_p = rst_n && out_valid && !out_ready;
    held = {out_last, out_bytes_valid, out_data};
  end
  task automatic send_words(input int id, input int nbytes, input int nw);
    rx_bus = '0;
    rx_bus.start = 1'b1;
    @(posedge clk); #1;
    for (int w = 0; w < nw; w++) begin
      rx_bus = '0;
      rx_bus.data_valid = 1'b1;
      rx_bus.bytes_valid = (nbytes - 4 * w >= 4) ? 3'd4 : 3'(nbytes - 4 * w);
      rx_bus.data = word(id, w);
      @(posedge clk); #1;
    end
    rx_bus = '0;
  endtask
  task automatic expect_frame(input int id, input int nbytes);
    int nw = (nbytes + 3) / 4;
    for (int w = 0; w < nw; w++)
      exp_q.push_back('{word(id, w), (nbytes - 4 * w >= 4) ? 3'd4 : 3'(nbytes - 4 * w), w == nw - 1, 16'(nbytes), 0});
    exp_ptr += 6'(nw);
  endtask
  task automatic drain();
    int n = exp_q.size();
    for (int k = 0; k < 300 && rx_q.size() < n; k++) @(negedge clk);
    repeat (4) @(negedge clk);
    check("beat_count", 64'(rx_q.size()), 64'(n));
    for (int k = 0; k < n && k < rx_q.size(); k++) begin
      check("data", 64'(rx_q[k].d), 64'(exp_q[k].d));
      check("bytes_valid", 64'(rx_q[k].bv), 64'(exp_q[k].bv));
      check("last", 64'(rx_q[k].last), 64'(exp_q[k].last));
      check("frame_len", 64'(rx_q[k].len), 64'(exp_q[k].len));
    end
    if (!toggle && n > 0 && rx_q.size() == n)
      check("rate", 64'(rx_q[n-1].cyc - rx_q[0].cyc), 64'(n - 1));
    rx_q.delete();
    exp_q.delete();
  endtask
  task automatic run_frame(input int id, input int nbytes, input bit drop, input bit dlv);
    send_words(id, nbytes, (nbytes + 3) / 4);
    if (drop) rx_bus.drop = 1'b1;
    else rx_bus.commit = 1'b1;
    @(posedge clk); #1;
    rx_bus = '0;
    if (dlv) expect_frame(id, nbytes);
    @(negedge clk);
    check("fv_at_n", 64'(out_frame_valid), 64'd0);
    @(negedge clk);
    check("fv_at_n1", 64'(out_frame_valid), 64'(dlv));
    check("ov_at_n1", 64'(out_valid), 64'd0);
    check("len_at_n1", 64'(out_frame_len), dlv ? 64'(nbytes) : 64'd0);
    @(negedge clk);
    check("ov_at_n2", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("ov_at_n3", 64'(out_valid), 64'(dlv));
    drain();
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_frame_valid"}, 64'(out_frame_valid), 64'd0);
    check({tag, "_frame_len"}, 64'(out_frame_len), 64'd0);
    check({tag, "_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_data"}, 64'(out_data), 64'd0);
    check({tag, "_bytes_valid"}, 64'(out_bytes_valid), 64'd0);
    check({tag, "_last"}, 64'(out_last), 64'd0);
    check({tag, "_perf_frames"}, 64'(perf_frames), 64'd0);
    check({tag, "_perf_crc"}, 64'(perf_crc_drops), 64'd0);
    check({tag, "_perf_ovf"}, 64'(perf_overflows), 64'd0);
  endtask
  initial begin
    vt[0] = '{64, 1'b0, 1, 0, 0};
    vt[1] = '{61, 1'b0, 2, 0, 0};
    vt[2] = '{100, 1'b1, 2, 1, 0};
    vt[3] = '{64, 1'b0, 3, 1, 0};
    vt[4] = '{200, 1'b0, 3, 1, 1};
    vt[5] = '{64, 1'b0, 4, 1, 1};
    rst_n = 1'b0;
    rx_bus = '0;
    exp_ptr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      run_frame(i + 1, vt[i].nbytes, vt[i].drop, vt[i].frames != (i == 0 ? 0 : vt[i-1].frames));
      check("perf_frames", 64'(perf_frames), 64'(vt[i].frames));
      check("perf_crc_drops", 64'(perf_crc_drops), 64'(vt[i].drops));
      check("perf_overflows", 64'(perf_overflows), 64'(vt[i].ovfs));
      if (vt[i].drop) check("wr_ptr_rollback", 64'(dut.wr_tmp_q), 64'(exp_ptr));
    end
    toggle = 1'b1;
    run_frame(10, 64, 1'b0, 1'b1);
    toggle = 1'b0;
    check("toggle_perf_frames", 64'(perf_frames), 64'd5);
    @(posedge clk); #1;
    send_words(20, 64, 16);
    rx_bus.commit = 1'b1;
    @(posedge clk); #1;
    send_words(21, 64, 5);
    check("stream_before_reset", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check_zero("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    rx_q.delete();
    exp_q.delete();
    exp_ptr = '0;
    run_frame(22, 64, 1'b0, 1'b1);
    check("post_reset_frames", 64'(perf_frames), 64'd1);
    check("post_reset_crc", 64'(perf_crc_drops), 64'd0);
    check("post_reset_ovf", 64'(perf_overflows), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
